// File: rtl/arbitro_rr4_if.sv
// Request/grant bundle between four requesters and the round-robin arbiter.
// With ARB_LOCK_EN defined the bundle also carries the lock line.
interface arbitro_rr4_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       valid;
`ifdef ARB_LOCK_EN
  logic       lock;

  modport master (output req, output lock, input gnt, input gnt_id, input valid);
  modport slave  (input req, input lock, output gnt, output gnt_id, output valid);
`else
  modport master (output req, input gnt, input gnt_id, input valid);
  modport slave  (input req, output gnt, output gnt_id, output valid);
`endif
endinterface

// File: rtl/arbitro_rr4.sv
// Four-way round-robin arbiter with a bounded hold time.
// The grant is registered and one-hot. Every change of owner goes through one
// idle cycle in which the grant is zero. An owner loses the grant when it
// drops its request, or after MAX_HOLD cycles if another requester is waiting.
// Optional macro ARB_LOCK_EN: adds bus.lock, which suppresses preemption
// while it is high.
module arbitro_rr4 #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 4
) (
  input logic          clk,
  input logic          rst_n,
  arbitro_rr4_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       gnt_id_q, gnt_id_d;
  logic [3:0]       gnt_q, gnt_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0]       winner;
  logic             found;
  logic [1:0]       idx;
  logic             lock;
  logic             competing;
  logic             own_drop;
  logic             preempt;

`ifdef ARB_LOCK_EN
  assign lock = bus.lock;
`else
  assign lock = 1'b0;
`endif

  // Search for the first requester, starting at the priority pointer.
  always_comb begin
    winner = ptr_q;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && bus.req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  // Next-state logic: grant from idle, or hold/release/preempt while busy.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_id_d  = gnt_id_q;
    gnt_d     = gnt_q;
    valid_d   = valid_q;
    cnt_d     = cnt_q;
    competing = |(bus.req & ~gnt_q);
    own_drop  = !bus.req[gnt_id_q];
    // A saturated counter still counts as expired, so a requester that shows
    // up after a long uncontested hold is not starved.
    preempt   = !lock && competing && (cnt_q >= CNT_W'(MAX_HOLD - 1));
    case (state_q)
      StIdle: begin
        if (found) begin
          state_d  = StBusy;
          gnt_d    = 4'b0001 << winner;
          gnt_id_d = winner;
          valid_d  = 1'b1;
          cnt_d    = '0;
        end
      end
      StBusy: begin
        if (cnt_q < CNT_W'(MAX_HOLD)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (own_drop || preempt) begin
          state_d = StIdle;
          gnt_d   = '0;
          valid_d = 1'b0;
          ptr_d   = gnt_id_q + 2'd1;
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset clears the grant immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      gnt_id_q <= '0;
      gnt_q    <= '0;
      valid_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_id_q <= gnt_id_d;
      gnt_q    <= gnt_d;
      valid_q  <= valid_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.gnt_id = gnt_id_q;
  assign bus.valid  = valid_q;

endmodule

// File: tb/tb_arbitro_rr4.sv
// Randomized bench for arbitro_rr4 against a cycle-level behavioural model.
// The model tracks the current owner and how many cycles it has held the grant.
module tb_arbitro_rr4;

  localparam int MaxHold = 8;

  logic clk;
  logic rst_n;
  arbitro_rr4_if bus ();

  arbitro_rr4 #(
    .MAX_HOLD (MaxHold),
    .CNT_W    (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  // Model state: owner < 0 means the resource is free.
  int owner;
  int held;
  int ptr;
  int last_id;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    owner   = -1;
    held    = 0;
    ptr     = 0;
    last_id = 0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic l);
    logic [3:0] others;
    if (owner < 0) begin
      for (int k = 0; k < 4; k++) begin
        if (owner < 0 && r[(ptr + k) % 4]) begin
          owner   = (ptr + k) % 4;
          held    = 1;
          last_id = owner;
        end
      end
    end else begin
      others = r & ~(4'b0001 << owner);
      if (!r[owner] || (!l && held >= MaxHold && others != 4'b0000)) begin
        ptr   = (owner + 1) % 4;
        owner = -1;
      end else if (held < 1000) begin
        held++;
      end
    end
  endtask

  task automatic compare_all(input string phase);
    logic [3:0] eg;
    eg = (owner < 0) ? 4'b0000 : (4'b0001 << owner);
    check_eq({phase, ".gnt"}, 32'(bus.gnt), 32'(eg));
    check_eq({phase, ".gnt_id"}, 32'(bus.gnt_id), 32'(last_id));
    check_eq({phase, ".valid"}, 32'(bus.valid), 32'(owner >= 0));
  endtask

  // Drive one cycle of stimulus, advance the model at the edge, check mid-cycle.
  task automatic cycle(input logic [3:0] r, input logic l, input string phase);
    bus.req = r;
`ifdef ARB_LOCK_EN
    bus.lock = l;
`endif
    @(posedge clk);
    model_step(r, l);
    @(negedge clk);
    compare_all(phase);
  endtask

  initial begin
    logic [3:0] r;
    logic       l;
    vectors     = 0;
    miscompares = 0;
    model_reset();
    rst_n   = 1'b0;
    bus.req = 4'b1111;
`ifdef ARB_LOCK_EN
    bus.lock = 1'b0;
`endif

    // Reset held with all requests up: nothing is granted.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      compare_all("reset");
    end
    rst_n = 1'b1;

    // Full contention: 8-cycle holds, one idle cycle, order 0,1,2,3,0.
    for (int i = 0; i < 40; i++) cycle(4'b1111, 1'b0, "rr");

    // Drain, then voluntary release hand-off from requester 2 to 1.
    cycle(4'b0000, 1'b0, "drain");
    cycle(4'b0000, 1'b0, "drain");
    for (int i = 0; i < 3; i++) cycle(4'b0100, 1'b0, "vrel");
    for (int i = 0; i < 4; i++) cycle(4'b0010, 1'b0, "vrel");
    cycle(4'b0000, 1'b0, "drain");

    // Uncontested hold long past saturation, then a competitor appears.
    for (int i = 0; i < 40; i++) cycle(4'b1000, 1'b0, "hold");
    for (int i = 0; i < 4; i++) cycle(4'b1001, 1'b0, "satpre");
    cycle(4'b0000, 1'b0, "drain");

    // Asynchronous reset in the middle of a grant to requester 1.
    for (int i = 0; i < 3; i++) cycle(4'b0010, 1'b0, "pre_ar");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    cycle(4'b1111, 1'b0, "post_ar");
    cycle(4'b0000, 1'b0, "drain");
    cycle(4'b0000, 1'b0, "drain");

`ifdef ARB_LOCK_EN
    // Lock keeps requester 0 past the hold limit; dropping it preempts.
    rst_n = 1'b0;
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) cycle(4'b0011, 1'b1, "lock");
    for (int i = 0; i < 4; i++) cycle(4'b0011, 1'b0, "unlock");
`endif

    // Random stimulus with sticky request lines.
    r = 4'b0000;
    l = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
      end
      if ($urandom_range(0, 99) == 0) r = 4'($urandom);
`ifdef ARB_LOCK_EN
      if ($urandom_range(0, 15) == 0) l = ~l;
`endif
      cycle(r, l, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
